imem_stream_loader: RTL and testbench

- Boot-time writer for the instruction memory, which the pipelined core only ever reads.
- Accepts a byte stream on a valid/ready interface (fed from a UART or switch-entry front end) and assembles big-endian 32-bit words.
- Writes each word to consecutive instruction-memory word addresses.
- Holds the core in reset until a complete, well-formed image has been loaded.

---
 rtl/imem_stream_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_stream_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: loads a length-prefixed big-endian byte stream into instruction memory.
// Ports: clk/reset (async, active-high); start pulse; in_data/in_valid/in_ready byte stream;
//        imem_we/imem_addr/imem_wdata write port; cpu_hold core reset; done/error status.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte after the payload).
module imem_stream_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHECK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  // Largest legal word count is the full memory capacity.
  localparam logic [32:0]       CAP  = 33'd1 << ADDR_W;

  state_t      state, next_state;
  logic [7:0]  len_hi;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [23:0] shreg;
  logic [31:0] wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic        accept;
  logic        start_ok;
  logic [32:0] len_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                    || (state == S_CHECK)
`endif
                    ;
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign len_full = {17'd0, len_hi, in_data};

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    imem_we    = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      S_IDLE:   if (start) next_state = S_LEN_HI;
      S_LEN_HI: if (accept) next_state = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_full == 33'd0) begin
`ifdef LOADER_CHECKSUM_EN
            next_state = S_CHECK;
`else
            next_state = S_DONE;
`endif
          end else if (len_full > CAP) begin
            next_state = S_ERR;
          end else begin
            next_state = S_DATA;
          end
        end
      end
      S_DATA:   if (accept && byte_idx == 2'd3) next_state = S_WRITE;
      S_WRITE: begin
        imem_we = 1'b1;
        // Counter decrements as WRITE retires, so a value of 1 marks the last word.
        if (word_cnt == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = S_CHECK;
`else
          next_state = S_DONE;
`endif
        end else begin
          next_state = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:  if (accept) next_state = (in_data == csum) ? S_DONE : S_ERR;
`endif
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) next_state = S_LEN_HI;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) next_state = S_LEN_HI;
      end
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi   <= 8'd0;
      word_cnt <= 16'd0;
      byte_idx <= 2'd0;
      shreg    <= 24'd0;
      wdata_q  <= 32'd0;
      addr_q   <= BASE;
`ifdef LOADER_CHECKSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      if (start_ok) begin
        addr_q <= BASE;
`ifdef LOADER_CHECKSUM_EN
        csum   <= 8'd0;
`endif
      end
      if (state == S_LEN_HI && accept) len_hi <= in_data;
      if (state == S_LEN_LO && accept) begin
        word_cnt <= {len_hi, in_data};
        byte_idx <= 2'd0;
      end
      if (state == S_DATA && accept) begin
        shreg    <= {shreg[15:0], in_data};
        byte_idx <= byte_idx + 2'd1;
        // Latch the full word only when complete so the write data stays stable between writes.
        if (byte_idx == 2'd3) wdata_q <= {shreg, in_data};
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ in_data;
`endif
      end
      if (state == S_WRITE) begin
        addr_q   <= addr_q + 1'b1;
        word_cnt <= word_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
module tb_imem_stream_loader;
  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_stream_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  wr_t         exp_q[$];
  logic [31:0] wq[$];
  bit          stall_mode;
  wr_t         mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the next expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && imem_we) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   imem_addr, imem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
          check("wr_data", imem_wdata, mon_e.data);
          check("ready_low_in_write", 32'(in_ready), 32'd0);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called and returns at a falling edge; transfers exactly one byte.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    if (stall_mode) begin
      in_valid = 1'b0;
      in_data  = $urandom_range(0, 255);
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total_cnt++;
      $display("FAIL byte_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input bit ok);
    int g = 0;
    while (!(done || error) && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) begin
      total_cnt++;
      $display("FAIL end_timeout: done=%0b error=%0b, expected one of them set", done, error);
    end
    check("end_done", 32'(done), 32'(ok));
    check("end_error", 32'(error), 32'(!ok));
    check("end_hold", 32'(cpu_hold), 32'(!ok));
    @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
  endtask

  // Reference: writes wq[i] to BASE+i when the length fits; success unless oversize or bad checksum.
  task automatic send_frame(input int n, input bit bad_ck, input bit mid_start);
    logic [7:0]  x = 8'd0;
    logic [7:0]  b;
    logic [15:0] len;
    int          cap;
    bit          ok;
    wr_t         w;
    cap = 1 << ADDR_W;
    len = 16'(n);
    ok  = (n <= cap) && !bad_ck;
    if (n <= cap) begin
      for (int i = 0; i < n; i++) begin
        w.addr = ADDR_W'(BASE_ADDR + i);
        w.data = wq[i];
        exp_q.push_back(w);
      end
    end
    pulse_start();
    check("hold_in_load", 32'(cpu_hold), 32'd1);
    check("done_clr", 32'(done), 32'd0);
    check("err_clr", 32'(error), 32'd0);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    if (n <= cap) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 3; k >= 0; k--) begin
          b = wq[i][8*k +: 8];
          x = x ^ b;
          send_byte(b);
          if (mid_start && i == 0 && k == 3) pulse_start();
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_ck ? (x ^ 8'h01) : x);
`endif
    end
    wait_end(ok);
  endtask

  task automatic fill_random(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom());
  endtask

  task automatic check_reset_values();
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'(BASE_ADDR));
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    stall_mode = 1'b0;
    #12;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single word 0x20080005.
    wq.delete();
    wq.push_back(32'h20080005);
    send_frame(1, 1'b0, 1'b0);

    // Three words with in_valid toggling.
    stall_mode = 1'b1;
    fill_random(3);
    send_frame(3, 1'b0, 1'b0);
    stall_mode = 1'b0;

    // Oversize length, then recovery.
    wq.delete();
    send_frame(16'h0101, 1'b0, 1'b0);
    fill_random(1);
    send_frame(1, 1'b0, 1'b0);

    // Reset after the 2nd byte of word 1: only word 0 is written.
    begin
      wr_t w;
      w.addr = ADDR_W'(BASE_ADDR);
      w.data = 32'h11223344;
      exp_q.push_back(w);
      pulse_start();
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66);
      #2 reset = 1'b1;
      #1;
      check_reset_values();
      check("abort_sb_empty", exp_q.size(), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
    end

`ifdef LOADER_CHECKSUM_EN
    wq.delete();
    wq.push_back(32'h8C0A0004);
    send_frame(1, 1'b0, 1'b0);
    send_frame(1, 1'b1, 1'b0);
`endif

    // Reload from DONE.
    fill_random(2);
    send_frame(2, 1'b0, 1'b0);
    wq.delete();
    wq.push_back(32'hFFFFFFFF);
    send_frame(1, 1'b0, 1'b0);

    // Empty image.
    wq.delete();
    send_frame(0, 1'b0, 1'b0);

    // Start pulse mid-load is ignored.
    fill_random(2);
    send_frame(2, 1'b0, 1'b1);

    // Random frames.
    for (int t = 0; t < 6; t++) begin
      stall_mode = 1'($urandom_range(0, 1));
      fill_random($urandom_range(1, 6));
      send_frame(wq.size(), 1'b0, 1'b0);
    end
    stall_mode = 1'b0;

    // Full capacity: last write lands on the top address.
    fill_random(1 << ADDR_W);
    send_frame(1 << ADDR_W, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
